// File: rtl/raymarch_pixel_scheduler.sv
// Raster-order pixel issuer for the raymarcher with a latency-matched tag line and credit-limited return FIFO.
// Optional RAYSCHED_AUTO_RESTART_EN: restart the next frame directly from DRAIN instead of returning to IDLE.
module raymarch_pixel_scheduler #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int CORDW         = 10,
  parameter int LATENCY       = 24,
  parameter int FIFO_DEPTH    = 32,
  parameter int ADDRW         = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic [CORDW-1:0] pixel_x,
  output logic [CORDW-1:0] pixel_y,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  output logic             fb_wr_valid,
  input  logic             fb_wr_ready,
  output logic [ADDRW-1:0] fb_wr_addr,
  output logic [23:0]      fb_wr_data,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a write transfers on any edge where fb_wr_valid && fb_wr_ready;
  // while valid is high and ready is low, addr/data stay fixed on the FIFO head.

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int OCCW = $clog2(LATENCY + FIFO_DEPTH + 1);
  localparam logic [CORDW-1:0] X_LAST = CORDW'(SCREEN_WIDTH - 1);
  localparam logic [CORDW-1:0] Y_LAST = CORDW'(SCREEN_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CORDW-1:0] x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic             frame_done_q, frame_done_d;

  logic [LATENCY-1:0]    dl_valid_q;
  logic [ADDRW-1:0]      dl_addr_q [LATENCY];
  logic [ADDRW+23:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PTRW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]       count_q;
  logic [ADDRW+23:0]     fifo_head;

  logic            issue, push, pop, fifo_empty, fifo_full, credit_ok, drain_done, last_pixel;
  logic [OCCW-1:0] inflight, occupancy;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + OCCW'(dl_valid_q[i]);
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNTW'(FIFO_DEPTH));
  assign push       = dl_valid_q[LATENCY-1];
  assign pop        = !fifo_empty && fb_wr_ready;
  // Credits cover both pixels still in the raymarcher and entries already buffered.
  assign occupancy  = inflight + OCCW'(count_q);
  assign credit_ok  = (occupancy < OCCW'(FIFO_DEPTH));
  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);
  assign drain_done = (inflight == '0) && fifo_empty && !push && !pop;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    px_d         = px_q;
    py_d         = py_q;
    addr_d       = addr_q;
    issue        = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue  = 1'b1;
          px_d   = x_q;
          py_d   = y_q;
          addr_d = addr_q + ADDRW'(1);
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + CORDW'(1);
          end else begin
            x_d = x_q + CORDW'(1);
          end
          if (last_pixel) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          frame_done_d = 1'b1;
`ifdef RAYSCHED_AUTO_RESTART_EN
          state_d = S_ISSUE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      px_q         <= '0;
      py_q         <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      dl_valid_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      px_q         <= px_d;
      py_q         <= py_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
      dl_valid_q[0] <= issue;
      for (int i = 1; i < LATENCY; i++) dl_valid_q[i] <= dl_valid_q[i-1];
      if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Address tags and FIFO storage carry no reset; only the valid bits and pointers matter.
  always_ff @(posedge clk) begin
    dl_addr_q[0] <= addr_q;
    for (int i = 1; i < LATENCY; i++) dl_addr_q[i] <= dl_addr_q[i-1];
    if (push) fifo_mem_q[wr_ptr_q] <= {dl_addr_q[LATENCY-1], red, green, blue};
  end

  assert property (@(posedge clk) disable iff (reset) !(push && fifo_full && !pop));

  assign fifo_head   = fifo_mem_q[rd_ptr_q];
  assign fb_wr_valid = !fifo_empty;
  assign fb_wr_addr  = fb_wr_valid ? fifo_head[ADDRW+23:24] : '0;
  assign fb_wr_data  = fb_wr_valid ? fifo_head[23:0] : '0;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = frame_done_q;
  assign pixel_x     = px_q;
  assign pixel_y     = py_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_raymarch_pixel_scheduler.sv
// Directed bench for raymarch_pixel_scheduler on a 4x2 screen, latency 3, FIFO depth 8.
// Build with RAYSCHED_AUTO_RESTART_EN defined to run the continuous-frame sequence instead.
module tb_raymarch_pixel_scheduler;
  localparam int W = 4, H = 2, L = 3, D = 8, CORDW = 10, ADDRW = 8;

  logic             clk = 1'b0;
  logic             reset, start, fb_wr_ready;
  logic             busy, frame_done, fb_wr_valid;
  logic [CORDW-1:0] pixel_x, pixel_y;
  logic [7:0]       red, green, blue;
  logic [ADDRW-1:0] fb_wr_addr;
  logic [23:0]      fb_wr_data;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  raymarch_pixel_scheduler #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .CORDW(CORDW),
    .LATENCY(L), .FIFO_DEPTH(D), .ADDRW(ADDRW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .red(red), .green(green), .blue(blue),
    .fb_wr_valid(fb_wr_valid), .fb_wr_ready(fb_wr_ready), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .dbg_state_o(dbg_state)
  );

  // Raymarcher stand-in: the DUT's pixel register plus L-1 more stages gives a colour
  // that is stable on the edge L after the coordinate was issued.
  logic [CORDW-1:0] rx_q [L-1];
  logic [CORDW-1:0] ry_q [L-1];
  always @(posedge clk) begin
    rx_q[0] <= pixel_x;
    ry_q[0] <= pixel_y;
    for (int i = 1; i < L - 1; i++) begin
      rx_q[i] <= rx_q[i-1];
      ry_q[i] <= ry_q[i-1];
    end
  end
  assign red   = rx_q[L-2][7:0];
  assign green = ry_q[L-2][7:0];
  assign blue  = rx_q[L-2][7:0] + ry_q[L-2][7:0];

  typedef struct {
    logic [ADDRW-1:0] addr;
    logic [23:0]      data;
  } wr_vec_t;
  wr_vec_t vecs [W*H];

  logic [ADDRW+23:0] exp_q [$];
  int checks = 0, errors = 0, writes = 0, done_cnt = 0;
  logic             prev_stall = 1'b0;
  logic [ADDRW-1:0] prev_addr;
  logic [23:0]      prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted write is compared against the front of exp_q.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_addr_stable", 32'(fb_wr_addr), 32'(prev_addr));
        check("stall_data_stable", 32'(fb_wr_data), 32'(prev_data));
      end
      if (fb_wr_valid && fb_wr_ready) begin
        writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 32'(fb_wr_addr), 32'hffff_ffff);
        end else begin
          logic [ADDRW+23:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(fb_wr_addr), 32'(e[ADDRW+23:24]));
          check("wr_data", 32'(fb_wr_data), 32'(e[23:0]));
        end
      end
      if (frame_done) done_cnt++;
      prev_stall = fb_wr_valid && !fb_wr_ready;
      prev_addr  = fb_wr_addr;
      prev_data  = fb_wr_data;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_frame();
    for (int i = 0; i < W*H; i++) exp_q.push_back({vecs[i].addr, vecs[i].data});
  endtask

  // Pulse start for one edge; returns just after that edge (edge k).
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!frame_done && n < max_cycles);
    if (!frame_done) check("frame_done_timeout", 32'(n), 32'(max_cycles + 1));
  endtask

  task automatic end_of_frame_checks(input string tag);
    tick(6);
    check({tag, "_writes"}, 32'(writes), 32'(W*H));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic seen;
    vecs[0] = '{8'd0, 24'h00_00_00};
    vecs[1] = '{8'd1, 24'h01_00_01};
    vecs[2] = '{8'd2, 24'h02_00_02};
    vecs[3] = '{8'd3, 24'h03_00_03};
    vecs[4] = '{8'd4, 24'h00_01_01};
    vecs[5] = '{8'd5, 24'h01_01_02};
    vecs[6] = '{8'd6, 24'h02_01_03};
    vecs[7] = '{8'd7, 24'h03_01_04};

    reset = 1'b1;
    start = 1'b0;
    fb_wr_ready = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_pixel_x", 32'(pixel_x), 32'd0);
    check("rst_pixel_y", 32'(pixel_y), 32'd0);
    check("rst_wr_valid", 32'(fb_wr_valid), 32'd0);
    check("rst_wr_addr", 32'(fb_wr_addr), 32'd0);
    check("rst_wr_data", 32'(fb_wr_data), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen = seen | fb_wr_valid | busy;
    end
    check("idle_no_activity", 32'(seen), 32'd0);

`ifdef RAYSCHED_AUTO_RESTART_EN
    load_frame();
    load_frame();
    writes = 0;
    done_cnt = 0;
    seen = 1'b0;
    pulse_start();
    n = 0;
    begin
      int pulses = 0;
      int first_at = 0;
      do begin
        tick(1);
        n++;
        seen = seen | !busy;
        if (frame_done) begin
          pulses++;
          if (pulses == 1) first_at = n;
        end
      end while (pulses < 2 && n < 100);
      check("auto_first_done_edge", 32'(first_at), 32'd13);
      check("auto_second_done_edge", 32'(n), 32'd26);
      check("auto_done_pulses", 32'(pulses), 32'd2);
    end
    check("auto_busy_never_dropped", 32'(seen), 32'd0);
    check("auto_writes", 32'(writes), 32'(2*W*H));
    check("auto_exp_left", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("auto_reset_busy", 32'(busy), 32'd0);
`else
    // Full rate
    load_frame();
    writes = 0;
    done_cnt = 0;
    pulse_start();
    wait_done(100, n);
    check("full_done_edge", 32'(n), 32'd13);
    check("full_busy_drop_with_done", 32'(busy), 32'd0);
    end_of_frame_checks("full");

    // Backpressure
    load_frame();
    writes = 0;
    done_cnt = 0;
    fb_wr_ready = 1'b0;
    pulse_start();
    tick(20);
    check("bp_valid_held", 32'(fb_wr_valid), 32'd1);
    check("bp_head_addr", 32'(fb_wr_addr), 32'd0);
    check("bp_last_px", 32'(pixel_x), 32'(W - 1));
    check("bp_last_py", 32'(pixel_y), 32'(H - 1));
    check("bp_still_busy", 32'(busy), 32'd1);
    check("bp_no_writes", 32'(writes), 32'd0);
    fb_wr_ready = 1'b1;
    wait_done(100, n);
    end_of_frame_checks("bp");

    // Start pulses mid-frame are ignored
    load_frame();
    writes = 0;
    done_cnt = 0;
    pulse_start();
    tick(4);
    pulse_start();
    tick(3);
    pulse_start();
    wait_done(100, n);
    end_of_frame_checks("ign");
    tick(10);
    check("ign_no_second_frame", 32'(writes), 32'(W*H));

    // Reset mid-frame, then a clean frame
    writes = 0;
    done_cnt = 0;
    fb_wr_ready = 1'b0;
    pulse_start();
    tick(5);
    check("mid_px_after_5", 32'(pixel_x), 32'd0);
    check("mid_py_after_5", 32'(pixel_y), 32'd1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    fb_wr_ready = 1'b1;
    check("mid_rst_px", 32'(pixel_x), 32'd0);
    check("mid_rst_py", 32'(pixel_y), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen = seen | fb_wr_valid | busy | frame_done;
    end
    check("mid_rst_quiet", 32'(seen), 32'd0);
    check("mid_rst_writes", 32'(writes), 32'd0);
    load_frame();
    pulse_start();
    wait_done(100, n);
    check("mid_clean_done_edge", 32'(n), 32'd13);
    end_of_frame_checks("mid_clean");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
